// File: rtl/leiwand_rv32_bus_decoder_if.sv
// Core-side memory port plus the common slave-side bus of the leiwand_rv32 decoder.
// The decoder takes the slave modport; the core/SoC side takes the master modport.
interface leiwand_rv32_bus_decoder_if #(
    parameter int XLEN     = 32,
    parameter int N_SLAVES = 3
);
    logic                     i_mem_valid;
    logic                     o_mem_ready;
    logic [XLEN-1:0]          i_mem_addr;
    logic [XLEN-1:0]          i_mem_wdata;
    logic [XLEN/8-1:0]        i_mem_wen;
    logic [XLEN-1:0]          o_mem_rdata;
    logic                     o_mem_err;
    logic [XLEN-1:0]          o_fault_addr;
    logic [N_SLAVES-1:0]      o_s_valid;
    logic [N_SLAVES-1:0]      i_s_ready;
    logic [XLEN-1:0]          o_s_addr;
    logic [XLEN-1:0]          o_s_wdata;
    logic [XLEN/8-1:0]        o_s_wen;
    logic [N_SLAVES*XLEN-1:0] i_s_rdata;

    modport slave (
        input  i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wen, i_s_ready, i_s_rdata,
        output o_mem_ready, o_mem_rdata, o_mem_err, o_fault_addr,
        output o_s_valid, o_s_addr, o_s_wdata, o_s_wen
    );

    modport master (
        output i_mem_valid, i_mem_addr, i_mem_wdata, i_mem_wen, i_s_ready, i_s_rdata,
        input  o_mem_ready, o_mem_rdata, o_mem_err, o_fault_addr,
        input  o_s_valid, o_s_addr, o_s_wdata, o_s_wen
    );
endinterface

// File: rtl/leiwand_rv32_bus_decoder.sv
// Registered base/mask address decoder with per-access timeout and error response,
// so an unmapped or silent slave faults the core instead of hanging it.
module leiwand_rv32_bus_decoder_match #(
    parameter int              XLEN = 32,
    parameter logic [XLEN-1:0] BASE = '0,
    parameter logic [XLEN-1:0] MASK = '0
) (
    input  logic [XLEN-1:0] addr,
    output logic            hit
);
    assign hit = ((addr & MASK) == BASE);
endmodule

module leiwand_rv32_bus_decoder #(
    parameter int                         XLEN           = 32,
    parameter int                         N_SLAVES       = 3,
    parameter logic [N_SLAVES*XLEN-1:0]   SLAVE_BASE     = {32'h10000000, 32'h02000000, 32'h80000000},
    parameter logic [N_SLAVES*XLEN-1:0]   SLAVE_MASK     = {32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFFF000},
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    leiwand_rv32_bus_decoder_if.slave     bus
);
    localparam int BW = XLEN / 8;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BW-1:0]   wen;
    } req_t;

    state_t              state;
    req_t                req;
    logic [SW-1:0]       sel;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;
    logic [N_SLAVES-1:0] hit;
    logic [N_SLAVES-1:0] hit_oh;
    logic [SW-1:0]       hit_idx;
    logic                sel_ready;
    logic [XLEN-1:0]     sel_rdata;
    logic                timeout;

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_match
        leiwand_rv32_bus_decoder_match #(
            .XLEN (XLEN),
            .BASE (SLAVE_BASE[i*XLEN +: XLEN]),
            .MASK (SLAVE_MASK[i*XLEN +: XLEN])
        ) u_match (
            .addr (bus.i_mem_addr),
            .hit  (hit[i])
        );
    end

    // Lowest set bit wins when address windows overlap.
    assign hit_oh = hit & (~hit + N_SLAVES'(1));

    always_comb begin
        hit_idx   = '0;
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) hit_idx = SW'(i);
        end
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == SW'(i)) begin
                sel_ready = bus.i_s_ready[i];
                sel_rdata = bus.i_s_rdata[i*XLEN +: XLEN];
            end
        end
    end

    // Saturating wait counter; TIMEOUT_CYCLES of 0 never fires.
    assign cnt_next = (&cnt) ? cnt : cnt + CW'(1);
    assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt_next == TMO);

    assign bus.o_s_addr  = req.addr;
    assign bus.o_s_wdata = req.wdata;
    assign bus.o_s_wen   = req.wen;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state            <= IDLE;
            req              <= '0;
            sel              <= '0;
            cnt              <= '0;
            bus.o_s_valid    <= '0;
            bus.o_mem_ready  <= 1'b0;
            bus.o_mem_err    <= 1'b0;
            bus.o_mem_rdata  <= '0;
            bus.o_fault_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_mem_valid) begin
                        req <= '{addr: bus.i_mem_addr, wdata: bus.i_mem_wdata, wen: bus.i_mem_wen};
                        sel <= hit_idx;
                        cnt <= '0;
                        if (|hit) begin
                            bus.o_s_valid <= hit_oh;
                            state         <= ACCESS;
                        end else begin
                            bus.o_mem_ready  <= 1'b1;
                            bus.o_mem_err    <= 1'b1;
                            bus.o_mem_rdata  <= '0;
                            bus.o_fault_addr <= bus.i_mem_addr;
                            state            <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready) begin
                        bus.o_s_valid   <= '0;
                        bus.o_mem_ready <= 1'b1;
                        bus.o_mem_err   <= 1'b0;
                        bus.o_mem_rdata <= sel_rdata;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt_next;
                        if (timeout) begin
                            bus.o_s_valid    <= '0;
                            bus.o_mem_ready  <= 1'b1;
                            bus.o_mem_err    <= 1'b1;
                            bus.o_mem_rdata  <= '0;
                            bus.o_fault_addr <= req.addr;
                            state            <= RESP;
                        end
                    end
                end
                RESP: begin
                    bus.o_mem_ready <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_leiwand_rv32_bus_decoder.sv
// Directed bench for leiwand_rv32_bus_decoder: a default-map instance with a short timeout
// and an overlapping-map instance; responses are checked against a scoreboard queue.
module tb_leiwand_rv32_bus_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    leiwand_rv32_bus_decoder_if #(.XLEN(32), .N_SLAVES(3)) a ();
    leiwand_rv32_bus_decoder_if #(.XLEN(32), .N_SLAVES(3)) b ();

    leiwand_rv32_bus_decoder #(
        .XLEN(32), .N_SLAVES(3), .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (a)
    );

    leiwand_rv32_bus_decoder #(
        .XLEN(32), .N_SLAVES(3),
        .SLAVE_BASE({32'h10000000, 32'h80000000, 32'h80000000}),
        .TIMEOUT_CYCLES(255)
    ) dut_ov (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (b)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_fault = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response side of the scoreboard: every ready strobe pops one expectation.
    always @(negedge clk) begin
        if (rst_n && a.o_mem_ready) begin
            chk("sb_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("sb_rdata", a.o_mem_rdata, e.rdata);
                chk("sb_err", 32'(a.o_mem_err), 32'(e.err));
            end
        end
    end

    // sl < 0: unmapped. waits < 0: slave never answers (timeout after 4 cycles).
    task automatic do_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wen, input int sl, input int waits,
                             input logic [31:0] rd, input bit drop);
        exp_t       e;
        logic [2:0] oh;
        int         lat, vcyc, exp_lat, exp_vcyc;
        bit         got;
        oh = (sl >= 0) ? 3'(3'b001 << sl) : 3'b000;
        a.i_s_rdata = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
        if (sl >= 0) a.i_s_rdata[sl*32 +: 32] = rd;
        if (sl < 0) begin
            e.rdata = '0; e.err = 1'b1; exp_lat = 1; exp_vcyc = 0; exp_fault = addr;
        end else if (waits < 0) begin
            e.rdata = '0; e.err = 1'b1; exp_lat = 5; exp_vcyc = 4; exp_fault = addr;
        end else begin
            e.rdata = rd; e.err = 1'b0; exp_lat = waits + 2; exp_vcyc = waits + 1;
        end
        a.i_mem_valid = 1'b1;
        a.i_mem_addr  = addr;
        a.i_mem_wdata = wdata;
        a.i_mem_wen   = wen;
        q.push_back(e);
        lat = 0; vcyc = 0; got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            a.i_s_ready = '0;
            if (drop) a.i_mem_valid = 1'b0;
            if (a.o_mem_ready) begin
                got = 1'b1;
            end else if (a.o_s_valid != 3'b000) begin
                vcyc++;
                chk({tag, "_s_valid"}, 32'(a.o_s_valid), 32'(oh));
                chk({tag, "_s_addr"}, a.o_s_addr, addr);
                chk({tag, "_s_wdata"}, a.o_s_wdata, wdata);
                chk({tag, "_s_wen"}, 32'(a.o_s_wen), 32'(wen));
                if (waits >= 0 && vcyc == waits + 1) a.i_s_ready = oh;
                else a.i_s_ready = ~oh;
            end
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_valid_cycles"}, vcyc, exp_vcyc);
        a.i_mem_valid = 1'b0;
        a.i_s_ready   = '0;
        tick();
        chk({tag, "_ready_one_cycle"}, 32'(a.o_mem_ready), 32'd0);
        chk({tag, "_rdata_hold"}, a.o_mem_rdata, e.rdata);
        chk({tag, "_fault_addr"}, a.o_fault_addr, exp_fault);
    endtask

    initial begin
        a.i_mem_valid = 1'b0; a.i_mem_addr = '0; a.i_mem_wdata = '0; a.i_mem_wen = '0;
        a.i_s_ready = '0; a.i_s_rdata = '0;
        b.i_mem_valid = 1'b0; b.i_mem_addr = '0; b.i_mem_wdata = '0; b.i_mem_wen = '0;
        b.i_s_ready = '0; b.i_s_rdata = '0;

        #3;
        chk("rst_mem_ready", 32'(a.o_mem_ready), 32'd0);
        chk("rst_mem_err", 32'(a.o_mem_err), 32'd0);
        chk("rst_s_valid", 32'(a.o_s_valid), 32'd0);
        chk("rst_rdata", a.o_mem_rdata, 32'd0);
        chk("rst_s_addr", a.o_s_addr, 32'd0);
        chk("rst_s_wdata", a.o_s_wdata, 32'd0);
        chk("rst_s_wen", 32'(a.o_s_wen), 32'd0);
        chk("rst_fault", a.o_fault_addr, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        do_access("rd_s0", 32'h80000010, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        do_access("wr_s1", 32'h02004000, 32'h12345678, 4'hF, 1, 3, 32'hCAFE0001, 1'b0);
        do_access("unmapped", 32'h40000000, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0);
        do_access("timeout_s2", 32'h10000004, 32'h0, 4'h0, 2, -1, 32'h0, 1'b0);
        do_access("drop_s0", 32'h80000FFC, 32'h0, 4'h0, 0, 1, 32'h0BADF00D, 1'b1);
        do_access("past_s2", 32'h10000010, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0);
        do_access("edge_s2", 32'h1000000C, 32'hA5A5A5A5, 4'h3, 2, 3, 32'h55AA1234, 1'b0);

        // Reset while the slave is stalling: everything clears without a clock edge.
        a.i_mem_valid = 1'b1; a.i_mem_addr = 32'h02000008; a.i_mem_wdata = 32'h77; a.i_mem_wen = 4'h1;
        tick(); tick();
        chk("pre_rst_s_valid", 32'(a.o_s_valid), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s_valid", 32'(a.o_s_valid), 32'd0);
        chk("arst_mem_ready", 32'(a.o_mem_ready), 32'd0);
        chk("arst_s_addr", a.o_s_addr, 32'd0);
        chk("arst_s_wdata", a.o_s_wdata, 32'd0);
        chk("arst_fault", a.o_fault_addr, 32'd0);
        exp_fault = '0;
        a.i_mem_valid = 1'b0;
        tick(); tick();
        chk("rst_hold_ready", 32'(a.o_mem_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        do_access("post_rst", 32'h80000020, 32'h0, 4'h0, 0, 0, 32'h600DCAFE, 1'b0);

        // Overlapping windows: slave 0 and 1 both match, slave 0 must win.
        b.i_mem_valid = 1'b1; b.i_mem_addr = 32'h80000000;
        b.i_s_rdata = {32'h0, 32'h11111111, 32'h00C0FFEE};
        tick();
        chk("ov_s_valid", 32'(b.o_s_valid), 32'd1);
        b.i_s_ready = 3'b011;
        tick();
        chk("ov_ready", 32'(b.o_mem_ready), 32'd1);
        chk("ov_rdata", b.o_mem_rdata, 32'h00C0FFEE);
        chk("ov_err", 32'(b.o_mem_err), 32'd0);
        b.i_mem_valid = 1'b0; b.i_s_ready = '0;
        tick();

        chk("sb_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
